// File: rtl/modulo_contador_rolhas.sv
// Cork stock counter: synchronises the dispense/refill requests, drives the release
// actuator for a fixed number of cycles, and keeps the stock count saturated to 0..99.
module modulo_contador_rolhas #(
  parameter int RELEASE_CYCLES = 4,
  parameter int REFILL_QTY     = 15,
  parameter int LOW_THRESHOLD  = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dispense_req,
  input  logic       refill_req,
  output logic [6:0] count,
  output logic       cork_release,
  output logic       dispense_ack,
  output logic       dispense_reject,
  output logic       empty,
  output logic       low_stock,
  output logic       full
);

  localparam logic [6:0] MAX_COUNT  = 7'd99;
  localparam logic [3:0] REL_LOAD   = 4'(RELEASE_CYCLES);
  localparam logic [7:0] REFILL_AMT = 8'(REFILL_QTY);
  localparam logic [6:0] LOW_TH     = 7'(LOW_THRESHOLD);

  typedef enum logic [1:0] {IDLE, RELEASE, WAIT_LOW} state_t;

  state_t     state;
  logic [3:0] rel_cnt;
  logic       refill_pending;
  logic       disp_p0, disp_p1, disp_p2;
  logic       fill_p0, fill_p1, fill_p2;
  logic       disp_ev, fill_ev;

  // Sum is formed one bit wider than count so the clamp sees values past 99.
  function automatic logic [6:0] sat_refill(input logic [6:0] cur);
    logic [7:0] sum;
    sum = {1'b0, cur} + REFILL_AMT;
    return (sum > {1'b0, MAX_COUNT}) ? MAX_COUNT : sum[6:0];
  endfunction

  // Stage p0/p1: two-flop synchroniser; stage p2: edge-detect history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_p0 <= 1'b0;
      disp_p1 <= 1'b0;
      disp_p2 <= 1'b0;
      fill_p0 <= 1'b0;
      fill_p1 <= 1'b0;
      fill_p2 <= 1'b0;
    end else begin
      disp_p0 <= dispense_req;
      disp_p1 <= disp_p0;
      disp_p2 <= disp_p1;
      fill_p0 <= refill_req;
      fill_p1 <= fill_p0;
      fill_p2 <= fill_p1;
    end
  end

  assign disp_ev = disp_p1 & ~disp_p2;
  assign fill_ev = fill_p1 & ~fill_p2;

  // Control stage: FSM, stock count and registered actuator/handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      rel_cnt         <= 4'd0;
      count           <= 7'd0;
      refill_pending  <= 1'b0;
      cork_release    <= 1'b0;
      dispense_ack    <= 1'b0;
      dispense_reject <= 1'b0;
    end else begin
      dispense_ack    <= 1'b0;
      dispense_reject <= 1'b0;
      if (fill_ev && !refill_pending) refill_pending <= 1'b1;
      case (state)
        IDLE: begin
          if (disp_ev) begin
            if (count != 7'd0) begin
              state        <= RELEASE;
              rel_cnt      <= REL_LOAD;
              cork_release <= 1'b1;
            end else begin
              state           <= WAIT_LOW;
              dispense_reject <= 1'b1;
            end
          end else if (refill_pending) begin
            // Pending is already set here, so the set above cannot collide with this clear.
            count          <= sat_refill(count);
            refill_pending <= 1'b0;
          end
        end
        RELEASE: begin
          if (rel_cnt == 4'd1) begin
            cork_release <= 1'b0;
            count        <= count - 7'd1;
            dispense_ack <= 1'b1;
            state        <= WAIT_LOW;
          end else begin
            rel_cnt <= rel_cnt - 4'd1;
          end
        end
        WAIT_LOW: begin
          if (!disp_p1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign empty     = (count == 7'd0);
  assign low_stock = (count < LOW_TH);
  assign full      = (count == MAX_COUNT);

endmodule

// File: tb/tb_modulo_contador_rolhas.sv
// Bench for the cork counter: vector table, hand-written corner sequences and
// randomised request traffic checked against a transaction-level stock model.
module tb_modulo_contador_rolhas;

  logic       clk;
  logic       reset_n;
  logic       dispense_req;
  logic       refill_req;
  logic [6:0] count;
  logic       cork_release;
  logic       dispense_ack;
  logic       dispense_reject;
  logic       empty;
  logic       low_stock;
  logic       full;

  modulo_contador_rolhas dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .dispense_req    (dispense_req),
    .refill_req      (refill_req),
    .count           (count),
    .cork_release    (cork_release),
    .dispense_ack    (dispense_ack),
    .dispense_reject (dispense_reject),
    .empty           (empty),
    .low_stock       (low_stock),
    .full            (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Running totals of output activity, sampled on the falling edge.
  int rel_total  = 0;
  int ack_total  = 0;
  int rej_total  = 0;
  int low4_total = 0;

  always @(negedge clk) begin
    if (cork_release)    rel_total  <= rel_total + 1;
    if (dispense_ack)    ack_total  <= ack_total + 1;
    if (dispense_reject) rej_total  <= rej_total + 1;
    if (low_stock && count == 7'd4) low4_total <= low4_total + 1;
  end

  typedef struct {
    bit disp;
    int hold;
    int cnt;
    int rel;
    int ack;
    int rej;
    bit emp;
    bit low;
    bit ful;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    dispense_req = 1'b0;
    refill_req   = 1'b0;
    reset_n      = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // One request pulse of 'hold' cycles, then enough idle time for the FSM to settle.
  task automatic do_op(input bit disp, input int hold,
                       output int d_rel, output int d_ack, output int d_rej);
    int r0, a0, j0;
    r0 = rel_total;
    a0 = ack_total;
    j0 = rej_total;
    if (disp) dispense_req = 1'b1;
    else      refill_req   = 1'b1;
    repeat (hold) @(negedge clk);
    dispense_req = 1'b0;
    refill_req   = 1'b0;
    repeat (16) @(negedge clk);
    d_rel = rel_total - r0;
    d_ack = ack_total - a0;
    d_rej = rej_total - j0;
  endtask

  task automatic check_flags(input string tag, input int exp_cnt);
    check({tag, " count"},     int'(count),     exp_cnt);
    check({tag, " empty"},     int'(empty),     (exp_cnt == 0)  ? 1 : 0);
    check({tag, " low_stock"}, int'(low_stock), (exp_cnt < 5)   ? 1 : 0);
    check({tag, " full"},      int'(full),      (exp_cnt == 99) ? 1 : 0);
  endtask

  initial begin
    int d_rel, d_ack, d_rej;
    int r0, a0, l0;
    int ref_cnt;
    bit found;
    bit op_disp;
    int op_hold;

    vecs[0]  = '{1, 3,  0, 0, 0, 1, 1, 1, 0};
    vecs[1]  = '{0, 2, 15, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 1, 30, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 4, 45, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 2, 60, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{0, 3, 75, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{0, 2, 90, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{0, 2, 99, 0, 0, 0, 0, 0, 1};
    vecs[8]  = '{0, 5, 99, 0, 0, 0, 0, 0, 1};
    vecs[9]  = '{1, 2, 98, 4, 1, 0, 0, 0, 0};
    vecs[10] = '{1, 6, 97, 4, 1, 0, 0, 0, 0};

    dispense_req = 1'b0;
    refill_req   = 1'b0;
    reset_n      = 1'b0;
    repeat (2) @(negedge clk);
    check("reset count",           int'(count),           0);
    check("reset empty",           int'(empty),           1);
    check("reset low_stock",       int'(low_stock),       1);
    check("reset full",            int'(full),            0);
    check("reset cork_release",    int'(cork_release),    0);
    check("reset dispense_ack",    int'(dispense_ack),    0);
    check("reset dispense_reject", int'(dispense_reject), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven walk from empty through saturation.
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].disp, vecs[i].hold, d_rel, d_ack, d_rej);
      check($sformatf("vec%0d count", i),     int'(count),     vecs[i].cnt);
      check($sformatf("vec%0d release", i),   d_rel,           vecs[i].rel);
      check($sformatf("vec%0d ack", i),       d_ack,           vecs[i].ack);
      check($sformatf("vec%0d reject", i),    d_rej,           vecs[i].rej);
      check($sformatf("vec%0d empty", i),     int'(empty),     int'(vecs[i].emp));
      check($sformatf("vec%0d low_stock", i), int'(low_stock), int'(vecs[i].low));
      check($sformatf("vec%0d full", i),      int'(full),      int'(vecs[i].ful));
    end

    // Refill latency: count reaches 15 within 4 cycles of the first sampled edge.
    do_reset();
    refill_req = 1'b1;
    @(negedge clk);
    refill_req = 1'b0;
    repeat (3) @(negedge clk);
    check("refill latency count", int'(count), 15);
    repeat (4) @(negedge clk);

    // Held dispense: exactly one release of 4 cycles, no repeat until re-pressed.
    r0 = rel_total;
    a0 = ack_total;
    dispense_req = 1'b1;
    repeat (20) @(negedge clk);
    check("held release cycles", rel_total - r0, 4);
    check("held ack count",      ack_total - a0, 1);
    check("held count",          int'(count),    14);
    repeat (10) @(negedge clk);
    check("held no second release", rel_total - r0, 4);
    dispense_req = 1'b0;
    repeat (4) @(negedge clk);
    do_op(1'b1, 2, d_rel, d_ack, d_rej);
    check("repress release cycles", d_rel,       4);
    check("repress ack",            d_ack,       1);
    check("repress count",          int'(count), 13);

    // Simultaneous dispense and refill at count 5.
    do_reset();
    do_op(1'b0, 2, d_rel, d_ack, d_rej);
    for (int i = 0; i < 10; i++) do_op(1'b1, 1, d_rel, d_ack, d_rej);
    check_flags("prep5", 5);
    r0 = rel_total;
    a0 = ack_total;
    l0 = low4_total;
    dispense_req = 1'b1;
    refill_req   = 1'b1;
    repeat (2) @(negedge clk);
    dispense_req = 1'b0;
    refill_req   = 1'b0;
    repeat (16) @(negedge clk);
    check("simul release cycles", rel_total - r0, 4);
    check("simul ack",            ack_total - a0, 1);
    check("simul saw count4 low", (low4_total - l0 > 0) ? 1 : 0, 1);
    check_flags("simul final", 19);

    // Reset during the second release cycle.
    do_reset();
    do_op(1'b0, 2, d_rel, d_ack, d_rej);
    a0 = ack_total;
    dispense_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (cork_release) found = 1'b1;
    end
    check("abort release started", int'(found), 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort cork_release", int'(cork_release), 0);
    check("abort count",        int'(count),        0);
    check("abort empty",        int'(empty),        1);
    dispense_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort no ack",    ack_total - a0, 0);
    check("abort count end", int'(count),    0);

    // Request already high when reset releases yields exactly one event.
    @(negedge clk);
    reset_n    = 1'b0;
    refill_req = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("held-through-reset count", int'(count), 15);
    repeat (20) @(negedge clk);
    check("held-through-reset single", int'(count), 15);
    refill_req = 1'b0;
    repeat (4) @(negedge clk);

    // Randomised traffic against a transaction-level stock model.
    do_reset();
    ref_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      op_disp = ($urandom_range(0, 99) < 55);
      op_hold = $urandom_range(1, 6);
      do_op(op_disp, op_hold, d_rel, d_ack, d_rej);
      if (op_disp) begin
        if (ref_cnt > 0) begin
          ref_cnt--;
          check($sformatf("rnd%0d release", i), d_rel, 4);
          check($sformatf("rnd%0d ack", i),     d_ack, 1);
          check($sformatf("rnd%0d reject", i),  d_rej, 0);
        end else begin
          check($sformatf("rnd%0d release", i), d_rel, 0);
          check($sformatf("rnd%0d ack", i),     d_ack, 0);
          check($sformatf("rnd%0d reject", i),  d_rej, 1);
        end
      end else begin
        ref_cnt = (ref_cnt + 15 > 99) ? 99 : ref_cnt + 15;
        check($sformatf("rnd%0d release", i), d_rel, 0);
        check($sformatf("rnd%0d ack", i),     d_ack, 0);
        check($sformatf("rnd%0d reject", i),  d_rej, 0);
      end
      check_flags($sformatf("rnd%0d", i), ref_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
